pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum S_FETCH or S_MEM wait before a timeout halt (range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port addr  input  32  current PC from programcounter.
REQ-005 SHALL have port pc_update  input  1  programcounter acknowledge pulse (one cycle after PCwrite).
REQ-006 SHALL have port instr  input  32  instruction word from instruction memory.
REQ-007 SHALL have port imem_valid  input  1  instr valid for current addr.
REQ-008 SHALL have port rs1_data  input  32  register-file rs1 read value.
REQ-009 SHALL have port imm  input  32  sign-extended immediate from the immediate generator.
REQ-010 SHALL have port cmp_true  input  1  branch condition result from the ALU/comparator.
REQ-011 SHALL have port dmem_ready  input  1  data-memory access complete.
REQ-012 SHALL have port imem_req  output  1  fetch request.
REQ-013 SHALL have port dmem_req  output  1  load/store request.
REQ-014 SHALL have port ir  output  32  latched instruction.
REQ-015 SHALL have port PCwrite  output  1  one-cycle PC write strobe.
REQ-016 SHALL have port new_count  output  32  next PC value.
REQ-017 SHALL have port halted  output  1  sequencer stopped.
REQ-018 SHALL have port err_code  output  2  00 none, 01 misaligned target, 10 timeout, 11 ECALL/EBREAK.

Function
REQ-019 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, PCWAIT, HALT.
REQ-020 FETCH: imem_req=1; on imem_valid, latch instr into ir and go to DECODE; otherwise stay.
REQ-021 DECODE: one cycle; go to EXEC.
REQ-022 EXEC: compute new_count from ir[6:0]; 0000011/0100011 -> MEM; 1110011 -> HALT with err_code 11; all others -> WB.
REQ-023 MEM: dmem_req=1; on dmem_ready go to WB.
REQ-024 new_count SHALL be registered in EXEC as follows.
- JAL (1101111): addr+imm.
- JALR (1100111): (rs1_data+imm) with bit0 cleared.
- BRANCH (1100011): cmp_true ? addr+imm : addr+4.
- Otherwise: addr+4.
- All sums are 32-bit modulo 2^32; carry discarded; 0xFFFFFFFC+4 = 0x00000000.
REQ-025 WB: if new_count[1:0]!=00, do not assert PCwrite; go to HALT with err_code 01. Else assert PCwrite=1 for exactly this cycle and go to PCWAIT.
REQ-026 PCWAIT: PCwrite=0; on pc_update=1 go to FETCH; otherwise stay.
REQ-027 Timeout counter: 8-bit, cleared on entry to FETCH/MEM, increments each waiting cycle; reaching TIMEOUT_CYCLES without imem_valid/dmem_ready -> HALT with err_code 10.
REQ-028 HALT: halted=1; all requests and PCwrite 0; ir, new_count, err_code frozen; exit only by rst.
REQ-029 PCwrite SHALL never be asserted in two consecutive cycles; imem_req and dmem_req SHALL never both be 1.
REQ-030 Valid/ready asserted in a cycle outside FETCH/MEM SHALL be ignored.

Reset
REQ-031 rst=1 at a posedge SHALL force FETCH and set ir=0, new_count=0x01000000, PCwrite=0, imem_req=0, dmem_req=0, halted=0, err_code=00, timeout counter=0.
REQ-032 rst SHALL override every state, including mid-MEM, PCWAIT and HALT; imem_req SHALL rise the first cycle after rst falls.

Verification
REQ-033 Add: addr=0x01000000, instr=0x00000013, imem_valid in the same cycle -> PCwrite pulse 4 cycles after the FETCH cycle with new_count=0x01000004, then PCWAIT until pc_update.
REQ-034 Branch: instr=0x00000063, imm=0xFFFFFFF8, addr=0x01000010; cmp_true=1 -> new_count=0x01000008; cmp_true=0 -> new_count=0x01000014.
REQ-035 JALR misaligned and aligned: rs1_data=0x01000001, imm=0x2 -> new_count=0x01000002 with no PCwrite, halted=1, err_code=01; rs1_data=0x01000003, imm=0 -> new_count=0x01000002, halt 01; rs1_data=0x01000000, imm=0x4 -> PCwrite with new_count=0x01000004.
REQ-036 Load: dmem_ready held low 3 cycles then high -> dmem_req high for 4 cycles, then WB; holding dmem_ready low for 255 cycles -> halted=1, err_code=10.
REQ-037 ECALL: instr=0x00000073 -> HALT with err_code 11 and no PCwrite; subsequent imem_valid pulses ignored; rst asserted mid-HALT -> FETCH next cycle with outputs at reset values.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : multi-cycle fetch/decode/execute/mem/writeback PC sequencer
// Revision 1.0
// ============================================================================
module pc_sequencer #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        pc_update,
   input  logic [31:0] instr,
   input  logic        imem_valid,
   input  logic [31:0] rs1_data,
   input  logic [31:0] imm,
   input  logic        cmp_true,
   input  logic        dmem_ready,
   output logic        imem_req,
   output logic        dmem_req,
   output logic [31:0] ir,
   output logic        PCwrite,
   output logic [31:0] new_count,
   output logic        halted,
   output logic [1:0]  err_code
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      PCWAIT = 3'd5,
      HALT   = 3'd6
   } state_t;

   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [6:0]  OP_JALR   = 7'b1100111;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [7:0]  tcount;
   logic [31:0] seq_pc;
   logic [31:0] rel_pc;
   logic [31:0] jalr_sum;
   logic [31:0] next_pc;

   always_comb begin
      seq_pc   = addr + 32'd4;
      rel_pc   = addr + imm;
      jalr_sum = rs1_data + imm;
      next_pc  = seq_pc;
      case (ir[6:0])
         OP_JAL:    next_pc = rel_pc;
         OP_JALR:   next_pc = jalr_sum & ~32'd1;
         OP_BRANCH: next_pc = cmp_true ? rel_pc : seq_pc;
         default:   next_pc = seq_pc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FETCH;
         ir        <= 32'd0;
         new_count <= 32'h0100_0000;
         PCwrite   <= 1'b0;
         imem_req  <= 1'b0;
         dmem_req  <= 1'b0;
         halted    <= 1'b0;
         err_code  <= 2'b00;
         tcount    <= 8'd0;
      end else begin
         PCwrite <= 1'b0;
         case (state)
            FETCH: begin
               // The request is raised one edge after reset; only then is a fetch in flight.
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_valid) begin
                  ir       <= instr;
                  imem_req <= 1'b0;
                  state    <= DECODE;
               end else if (tcount == TO_LAST) begin
                  imem_req <= 1'b0;
                  halted   <= 1'b1;
                  err_code <= 2'b10;
                  state    <= HALT;
               end else begin
                  tcount <= tcount + 8'd1;
               end
            end
            DECODE: state <= EXEC;
            EXEC: begin
               new_count <= next_pc;
               case (ir[6:0])
                  OP_LOAD, OP_STORE: begin
                     dmem_req <= 1'b1;
                     tcount   <= 8'd0;
                     state    <= MEM;
                  end
                  OP_SYSTEM: begin
                     halted   <= 1'b1;
                     err_code <= 2'b11;
                     state    <= HALT;
                  end
                  default: state <= WB;
               endcase
            end
            MEM: begin
               if (dmem_ready) begin
                  dmem_req <= 1'b0;
                  state    <= WB;
               end else if (tcount == TO_LAST) begin
                  dmem_req <= 1'b0;
                  halted   <= 1'b1;
                  err_code <= 2'b10;
                  state    <= HALT;
               end else begin
                  tcount <= tcount + 8'd1;
               end
            end
            WB: begin
               if (new_count[1:0] != 2'b00) begin
                  halted   <= 1'b1;
                  err_code <= 2'b01;
                  state    <= HALT;
               end else begin
                  PCwrite <= 1'b1;
                  state   <= PCWAIT;
               end
            end
            PCWAIT: begin
               if (pc_update) begin
                  imem_req <= 1'b1;
                  tcount   <= 8'd0;
                  state    <= FETCH;
               end
            end
            HALT: state <= HALT;
            default: state <= HALT;
         endcase
      end
   end

endmodule
`default_nettype wire
